kmeans_dispatch: RTL and testbench
==================================

// Module: kmeans_dispatch
// PURPOSE
//  Drives K k-means cluster cores over one shared 5-bit control bus per core. Streams NPIX pixels from a
//  sync-read pixel RAM, broadcasts each pixel, picks the argmin core distance and flags that core as closest.
//  Closes each pass with a mean update and iterates until all cores report stable means or MAX_ITER is hit.
//  Then runs one compare-only labelling pass that emits a cluster label per pixel.
// PARAMETERS
//  K         4     number of cluster cores (2..8)
//  NPIX      1024  pixels per pass (1..4096)
//  ADDR_W    12    pixel address width
//  MAX_ITER  16    training-pass limit
//  CORE_LAT  2     cycles from core enable-with-pixel to valid core distance
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  start        in   1        1-cycle pulse; begins a clustering run when idle
//  pix_addr     out  ADDR_W   pixel RAM read address
//  pix_rd       out  1        pixel RAM read strobe; data valid next cycle
//  pix_data     in   24       RGB888 pixel {R,G,B}
//  core_pixel   out  24       pixel broadcast to all cores
//  core_ctrl    out  5*K      per core k, [5k+4:5k] = {enable, compareOnly, isClosest, updateMean, allMeansStable}
//  core_dist    in   10*K     per core Manhattan distance, unsigned
//  core_stable  in   K        per core mean-stable flag, sampled in CHECK
//  core_busy    in   K        per core busy (divider running)
//  label        out  3        winning core index for label_addr
//  label_addr   out  ADDR_W   pixel address of label
//  label_valid  out  1        1-cycle pulse, labelling pass only
//  busy         out  1        high from accepted start until done
//  done         out  1        1-cycle pulse at end of labelling pass
//  converged    out  1        valid from done; 1 = stable before MAX_ITER
//  iter_count   out  5        completed training passes
// BEHAVIOUR
//  Reset (async, active-low): FSM=IDLE; every output 0, including core_ctrl (cores frozen); counters 0.
//  FSM: IDLE -> FETCH -> PRESENT -> WAIT -> SELECT -> (FETCH | UPDATE) -> CHECK -> (FETCH | LABEL_FETCH...) -> DONE -> IDLE.
//   IDLE: start=1 -> busy=1, addr=0, iter=0, mode=TRAIN -> FETCH. start is ignored while busy.
//   FETCH: pix_rd=1, pix_addr=addr; 1 cycle.
//   PRESENT: latch pix_data into core_pixel; enable=1 for all cores; compareOnly=1 iff mode=LABEL.
//   WAIT: hold enable; count CORE_LAT cycles, then core_dist is valid.
//   SELECT (1 cycle): w = argmin core_dist. Ties go to the lowest index.
//    TRAIN: isClosest=1 on core w only.
//    LABEL: label=w, label_addr=addr, label_valid=1.
//    If addr==NPIX-1: addr wraps to 0 -> UPDATE (TRAIN) or DONE (LABEL). Else addr+1 -> FETCH.
//   UPDATE: updateMean=1 to all cores while any core_busy=1 -> hold. All core_busy=0 for 1 cycle -> iter+1 -> CHECK.
//   CHECK: if &core_stable: allMeansStable=1 to all for 1 cycle, converged=1, mode=LABEL -> FETCH.
//    Else if iter==MAX_ITER: converged=0, mode=LABEL -> FETCH. Else -> FETCH (next TRAIN pass).
//   DONE: done=1 for 1 cycle, busy=0 -> IDLE. label, converged and iter_count hold until next start.
//  Per-pixel throughput: 3+CORE_LAT cycles (FETCH, PRESENT, WAIT, SELECT).
//  Arithmetic: distance compare is unsigned 10-bit; iter_count saturates at MAX_ITER; addr is ADDR_W bits.
//  Boundaries:
//   NPIX=1: every pass is one pixel.
//   core_busy already 0 on entry to UPDATE: leave after 1 cycle.
//   core_stable is don't-care outside CHECK.
//   Reset mid-run: immediate return to IDLE with all core_ctrl=0; no done pulse.
//   Only one isClosest is ever set per SELECT; isClosest never overlaps updateMean.
// TESTING
//  1. K=4, NPIX=4. Dists {30,10,20,40} on every pixel. All stable at first CHECK.
//     -> isClosest on core1 x4, iter_count=1, converged=1, labels 1,1,1,1 at addrs 0..3, one done pulse.
//  2. Tie: dists {7,7,7,7} -> winner/label=0.
//     Dists {9,3,3,8} -> label=1.
//  3. core_stable never all-1, MAX_ITER=3 -> exactly 3 UPDATE phases, converged=0, then labelling pass and done.
//  4. core_busy held high 5 cycles in UPDATE -> updateMean held 5+1 cycles; no FETCH until busy low.
//  5. Assert reset during WAIT of pixel 2 -> core_ctrl=0, busy=0 same cycle.
//     A new start restarts at addr 0, iter_count=0.
//  6. start pulsed while busy -> ignored; pixel ordering and iter_count unchanged.
//     NPIX=1 run completes with one label at addr 0.

Source files
------------

// File: rtl/kmeans_dispatch.sv
// Dispatcher for K k-means cluster cores: streams pixels, picks the argmin core,
// sequences mean updates until convergence, then runs one labelling pass.
module kmeans_dispatch #(
  parameter int unsigned K        = 4,
  parameter int unsigned NPIX     = 1024,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned CORE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd,
  input  logic [23:0]       pix_data,
  output logic [23:0]       core_pixel,
  output logic [5*K-1:0]    core_ctrl,
  input  logic [10*K-1:0]   core_dist,
  input  logic [K-1:0]      core_stable,
  input  logic [K-1:0]      core_busy,
  output logic [2:0]        label,
  output logic [ADDR_W-1:0] label_addr,
  output logic              label_valid,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [4:0]        iter_count
);

  localparam int unsigned WAIT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(CORE_LAT - 1);
  localparam logic [4:0]        ITER_MAX  = 5'(MAX_ITER);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_PRESENT, ST_WAIT, ST_SELECT, ST_UPDATE, ST_CHECK, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [4:0]          iter_d;
  logic                mode_q, mode_d;   // 0 = training, 1 = labelling
  logic                conv_d;
  logic                stable_pulse_d;
  logic [2:0]          win;
  logic [9:0]          best;
  logic [5*K-1:0]      ctrl_d;

  // Argmin over core distances; strict compare keeps ties on the lowest index.
  always_comb begin
    win  = 3'd0;
    best = core_dist[9:0];
    for (int k = 1; k < int'(K); k++) begin
      if (core_dist[10*k +: 10] < best) begin
        best = core_dist[10*k +: 10];
        win  = 3'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wait_d         = wait_q;
    iter_d         = iter_count;
    mode_d         = mode_q;
    conv_d         = converged;
    stable_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          iter_d  = 5'd0;
          mode_d  = 1'b0;
          conv_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:   state_d = ST_PRESENT;
      ST_PRESENT: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == LAST_WAIT) state_d = ST_SELECT;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      ST_SELECT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = mode_q ? ST_DONE : ST_UPDATE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_UPDATE: begin
        if (!(|core_busy)) begin
          if (iter_count < ITER_MAX) iter_d = iter_count + 5'd1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_FETCH;
        if (&core_stable) begin
          stable_pulse_d = 1'b1;
          conv_d         = 1'b1;
          mode_d         = 1'b1;
        end else if (iter_count == ITER_MAX) begin
          conv_d = 1'b0;
          mode_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Core control for the coming cycle; distances are sampled on the last WAIT cycle.
  always_comb begin
    ctrl_d = '0;
    for (int k = 0; k < int'(K); k++) begin
      ctrl_d[5*k+4] = (state_d == ST_PRESENT) || (state_d == ST_WAIT);
      ctrl_d[5*k+3] = ((state_d == ST_PRESENT) || (state_d == ST_WAIT)) && mode_q;
      ctrl_d[5*k+2] = (state_d == ST_SELECT) && !mode_q && (win == 3'(k));
      ctrl_d[5*k+1] = (state_d == ST_UPDATE);
      ctrl_d[5*k]   = stable_pulse_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wait_q      <= '0;
      mode_q      <= 1'b0;
      iter_count  <= 5'd0;
      converged   <= 1'b0;
      pix_addr    <= '0;
      pix_rd      <= 1'b0;
      core_pixel  <= 24'd0;
      core_ctrl   <= '0;
      label       <= 3'd0;
      label_addr  <= '0;
      label_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      mode_q      <= mode_d;
      iter_count  <= iter_d;
      converged   <= conv_d;
      pix_rd      <= (state_d == ST_FETCH);
      if (state_d == ST_FETCH) pix_addr <= addr_d;
      if (state_q == ST_PRESENT) core_pixel <= pix_data;
      core_ctrl   <= ctrl_d;
      label_valid <= (state_d == ST_SELECT) && mode_q;
      if ((state_d == ST_SELECT) && mode_q) begin
        label      <= win;
        label_addr <= addr_q;
      end
      busy        <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done        <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_kmeans_dispatch.sv
// Scoreboard bench for kmeans_dispatch: winners and labels queued at stimulus time,
// popped as isClosest / label_valid appear on the core bus.
module tb_kmeans_dispatch;

  localparam int unsigned K        = 4;
  localparam int unsigned NPIX     = 4;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned MAX_ITER = 3;
  localparam int unsigned CORE_LAT = 2;
  localparam int          BOUND    = 2000;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic start  = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  logic [23:0]       pix_data;
  logic [10*K-1:0]   core_dist   = '0;
  logic [K-1:0]      core_stable = '0;
  logic [K-1:0]      core_busy   = '0;

  logic [ADDR_W-1:0] pix_addr, label_addr, pix_addr1, label_addr1;
  logic              pix_rd, label_valid, busy, done, converged;
  logic              pix_rd1, label_valid1, busy1, done1, converged1;
  logic [23:0]       core_pixel, core_pixel1;
  logic [5*K-1:0]    core_ctrl, core_ctrl1;
  logic [2:0]        label, label1;
  logic [4:0]        iter_count, iter_count1;

  kmeans_dispatch #(.K(K), .NPIX(NPIX), .ADDR_W(ADDR_W), .MAX_ITER(MAX_ITER), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_addr(pix_addr), .pix_rd(pix_rd),
    .pix_data(pix_data), .core_pixel(core_pixel), .core_ctrl(core_ctrl), .core_dist(core_dist),
    .core_stable(core_stable), .core_busy(core_busy), .label(label), .label_addr(label_addr),
    .label_valid(label_valid), .busy(busy), .done(done), .converged(converged), .iter_count(iter_count));

  kmeans_dispatch #(.K(K), .NPIX(1), .ADDR_W(ADDR_W), .MAX_ITER(MAX_ITER), .CORE_LAT(CORE_LAT)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pix_addr(pix_addr1), .pix_rd(pix_rd1),
    .pix_data(pix_data), .core_pixel(core_pixel1), .core_ctrl(core_ctrl1), .core_dist(core_dist),
    .core_stable(core_stable), .core_busy(core_busy), .label(label1), .label_addr(label_addr1),
    .label_valid(label_valid1), .busy(busy1), .done(done1), .converged(converged1), .iter_count(iter_count1));

  logic [23:0] mem [0:NPIX-1];

  // Sync-read pixel RAM shared by both instances (only one runs at a time).
  always @(posedge clk) begin
    if (pix_rd)       pix_data <= mem[pix_addr[1:0]];
    else if (pix_rd1) pix_data <= mem[0];
  end

  logic [K-1:0] en_v, co_v, ic_v, um_v, ams_v;
  always_comb begin
    for (int k = 0; k < int'(K); k++) begin
      en_v[k]  = core_ctrl[5*k+4];
      co_v[k]  = core_ctrl[5*k+3];
      ic_v[k]  = core_ctrl[5*k+2];
      um_v[k]  = core_ctrl[5*k+1];
      ams_v[k] = core_ctrl[5*k];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int  exp_close[$];
  int  exp_lab[$];
  int  n_upd = 0, n_done = 0, n_ams = 0, upd_len = 0, exp_upd_len = 1;
  int  nbusy_cfg = 0, busy_cnt = 0;
  bit  chk_mode = 1'b0;
  int  n_lab1 = 0, n_ic1 = 0;
  logic [2:0]        lab1  = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [23:0]       pix1  = '0;

  // Cores stay busy for nbusy_cfg cycles after updateMean is first seen.
  always @(negedge clk) begin
    if (|um_v && busy_cnt < nbusy_cfg) begin
      core_busy = '1;
      busy_cnt++;
    end else begin
      core_busy = '0;
      if (!(|um_v)) busy_cnt = 0;
    end
  end

  // Scoreboard monitor for the NPIX=4 instance.
  always @(negedge clk) begin
    if (reset) begin
      if (|ic_v) begin
        if (exp_close.size() == 0) check("closest_extra", 32'(ic_v), 32'd0);
        else check("closest", 32'(ic_v), 32'd1 << exp_close.pop_front());
        check("closest_vs_update", 32'(um_v), 32'd0);
      end
      if (|en_v) begin
        check("enable_all", 32'(en_v), 32'hF);
        if (chk_mode) check("compare_only", 32'(co_v), (exp_close.size() == 0) ? 32'hF : 32'h0);
      end
      if (|um_v) begin
        upd_len++;
        check("no_fetch_in_update", 32'(pix_rd), 32'd0);
      end else if (upd_len != 0) begin
        n_upd++;
        check("update_len", 32'(upd_len), 32'(exp_upd_len));
        upd_len = 0;
      end
      if (|ams_v) n_ams++;
      if (label_valid) begin
        if (exp_lab.size() == 0) check("label_extra", 32'(label_valid), 32'd0);
        else begin
          int e;
          e = exp_lab.pop_front();
          check("label", 32'(label), 32'(e >> 16));
          check("label_addr", 32'(label_addr), 32'(e & 16'hFFFF));
          check("label_pixel", 32'(core_pixel), 32'(mem[label_addr[1:0]]));
        end
      end
      if (done) n_done++;
      if (label_valid1) begin
        n_lab1++;
        lab1  = label1;
        addr1 = label_addr1;
        pix1  = core_pixel1;
      end
      if (core_ctrl1[7]) n_ic1++;
    end
  end

  function automatic int ref_argmin(input int d0, input int d1, input int d2, input int d3);
    int d[4];
    int b;
    d = '{d0, d1, d2, d3};
    b = 3;
    for (int k = 2; k >= 0; k--) if (d[k] <= d[b]) b = k;
    return b;
  endfunction

  task automatic run(input string tag, input int d0, input int d1, input int d2, input int d3,
                     input bit all_stable, input int nbusy, input int passes, input bit conv,
                     input bit poke_start);
    int w;
    int cyc;
    w           = ref_argmin(d0, d1, d2, d3);
    core_dist   = {10'(d3), 10'(d2), 10'(d1), 10'(d0)};
    core_stable = all_stable ? 4'hF : 4'h7;
    nbusy_cfg   = nbusy;
    exp_upd_len = nbusy + 1;
    chk_mode    = 1'b1;
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < int'(NPIX); a++) exp_close.push_back(w);
    for (int a = 0; a < int'(NPIX); a++) exp_lab.push_back((w << 16) | a);
    n_upd = 0; n_done = 0; n_ams = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (poke_start) begin
      repeat (7) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < BOUND);
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    check({tag, "_updates"}, 32'(n_upd), 32'(passes));
    check({tag, "_iter"}, 32'(iter_count), 32'(passes));
    check({tag, "_converged"}, 32'(converged), 32'(conv));
    check({tag, "_stable_pulse"}, 32'(n_ams), conv ? 32'd1 : 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_close_left"}, 32'(exp_close.size()), 32'd0);
    check({tag, "_label_left"}, 32'(exp_lab.size()), 32'd0);
    exp_close.delete();
    exp_lab.delete();
  endtask

  initial begin
    int cyc;
    for (int a = 0; a < int'(NPIX); a++) mem[a] = 24'($urandom);
    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'(core_ctrl), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pix_rd", 32'(pix_rd), 32'd0);
    check("reset_iter", 32'(iter_count), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run("basic", 30, 10, 20, 40, 1'b1, 0, 1, 1'b1, 1'b0);
    run("tie",    7,  7,  7,  7, 1'b1, 0, 1, 1'b1, 1'b0);
    run("busy5",  9,  3,  3,  8, 1'b1, 5, 1, 1'b1, 1'b0);
    run("maxit", 12, 40,  5,  6, 1'b0, 0, 3, 1'b0, 1'b1);

    // Reset during WAIT of pixel 2.
    chk_mode    = 1'b0;
    core_dist   = {10'd40, 10'd20, 10'd10, 10'd30};
    core_stable = 4'hF;
    nbusy_cfg   = 0;
    exp_close.push_back(1);
    exp_close.push_back(1);
    n_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(pix_rd && pix_addr == 12'd2) && cyc < BOUND);
    check("rst_reach_px2", 32'(pix_rd && pix_addr == 12'd2), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_enable_before", 32'(en_v), 32'hF);
    reset = 1'b0;
    #1;
    check("rst_ctrl", 32'(core_ctrl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_close_left", 32'(exp_close.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(n_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_iter", 32'(iter_count), 32'd0);
    run("restart", 30, 10, 20, 40, 1'b1, 0, 1, 1'b1, 1'b0);

    // Single-pixel instance.
    chk_mode = 1'b0;
    core_dist   = {10'd40, 10'd20, 10'd10, 10'd30};
    core_stable = 4'hF;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    check("np1_busy", 32'(busy1), 32'd1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done1 && cyc < BOUND);
    check("np1_done_seen", 32'(done1), 32'd1);
    repeat (2) @(negedge clk);
    check("np1_labels", 32'(n_lab1), 32'd1);
    check("np1_label", 32'(lab1), 32'd1);
    check("np1_label_addr", 32'(addr1), 32'd0);
    check("np1_pixel", 32'(pix1), 32'(mem[0]));
    check("np1_closest", 32'(n_ic1), 32'd1);
    check("np1_iter", 32'(iter_count1), 32'd1);
    check("np1_converged", 32'(converged1), 32'd1);
    check("np1_pix_addr", 32'(pix_addr1), 32'd0);
    check("np1_pix_rd", 32'(pix_rd1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
